// File: rtl/prog_counter_if.sv
// Pin-side controls and counter outputs of prog_counter, bundled as one port.
// Latency: none (wires only).
// Backpressure: none; the pins are free-running levels and strobes.
interface prog_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             count_in;
    logic             load;
    logic             up_down;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] limit;
    logic             sat_mode;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             enabled;

    // Pin driver side
    modport master (
        output enable, count_in, load, up_down, data_in, limit, sat_mode,
        input  count, tc, enabled
    );

    // Counter side
    modport slave (
        input  enable, count_in, load, up_down, data_in, limit, sat_mode,
        output count, tc, enabled
    );
endinterface

// File: rtl/prog_counter.sv
// WIDTH-bit up/down counter fed by asynchronous pins, with limit, wrap/saturate and terminal-count pulse.
// Latency: pin change captured at edge 1, count/tc update at edge SYNC_STAGES+1, enabled at edge SYNC_STAGES.
// Backpressure: none; at most one count per two cycles, strobes narrower than 2 cycles may be lost.
module prog_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    prog_counter_if.slave io_bus
);

    // Synchroniser chains; bit 0 is the capturing stage, bit SYNC_STAGES-1 the usable one.
    logic [SYNC_STAGES-1:0] r_en_sync;
    logic [SYNC_STAGES-1:0] r_cnt_sync;
    logic [SYNC_STAGES-1:0] r_ld_sync;
    logic [SYNC_STAGES-1:0] r_ud_sync;
    logic [WIDTH-1:0]       r_data_sync [SYNC_STAGES];

    // One-cycle delay of the synchronised strobes for rising-edge detection.
    logic r_en_d;
    logic r_cnt_d;
    logic r_ld_d;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;

    logic             w_en_lvl;
    logic             w_en_rise;
    logic             w_cnt_rise;
    logic             w_ld_rise;
    logic             w_up;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_step_val;
    logic             w_boundary;

    // Shift every asynchronous pin through its synchroniser and keep the edge-detect delay flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en_sync  <= '0;
            r_cnt_sync <= '0;
            r_ld_sync  <= '0;
            r_ud_sync  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= '0;
            end
            r_en_d  <= 1'b0;
            r_cnt_d <= 1'b0;
            r_ld_d  <= 1'b0;
        end else begin
            r_en_sync  <= {r_en_sync[SYNC_STAGES-2:0],  io_bus.enable};
            r_cnt_sync <= {r_cnt_sync[SYNC_STAGES-2:0], io_bus.count_in};
            r_ld_sync  <= {r_ld_sync[SYNC_STAGES-2:0],  io_bus.load};
            r_ud_sync  <= {r_ud_sync[SYNC_STAGES-2:0],  io_bus.up_down};
            r_data_sync[0] <= io_bus.data_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end
            r_en_d  <= r_en_sync[SYNC_STAGES-1];
            r_cnt_d <= r_cnt_sync[SYNC_STAGES-1];
            r_ld_d  <= r_ld_sync[SYNC_STAGES-1];
        end
    end

    assign w_en_lvl   = r_en_sync[SYNC_STAGES-1];
    assign w_en_rise  = w_en_lvl & ~r_en_d;
    assign w_cnt_rise = r_cnt_sync[SYNC_STAGES-1] & ~r_cnt_d;
    assign w_ld_rise  = r_ld_sync[SYNC_STAGES-1] & ~r_ld_d;
    assign w_up       = r_ud_sync[SYNC_STAGES-1];
    assign w_data     = r_data_sync[SYNC_STAGES-1];

    // Next value for a single count step; the ">= limit" test also clamps out-of-range loads.
    always_comb begin
        w_step_val = r_count;
        w_boundary = 1'b0;
        if (w_up) begin
            if (r_count < io_bus.limit) begin
                w_step_val = r_count + WIDTH'(1);
            end else begin
                w_boundary = 1'b1;
                w_step_val = io_bus.sat_mode ? io_bus.limit : '0;
            end
        end else begin
            if (r_count != '0) begin
                w_step_val = r_count - WIDTH'(1);
            end else begin
                w_boundary = 1'b1;
                w_step_val = io_bus.sat_mode ? '0 : io_bus.limit;
            end
        end
    end

    // Counter update: enable rise clears, then load, then count; everything holds while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (w_en_rise) begin
                r_count <= '0;
            end else if (w_en_lvl) begin
                if (w_ld_rise) begin
                    r_count <= w_data;
                end else if (w_cnt_rise) begin
                    r_count <= w_step_val;
                    r_tc    <= w_boundary;
                end
            end
        end
    end

    assign io_bus.count   = r_count;
    assign io_bus.tc      = r_tc;
    assign io_bus.enabled = w_en_lvl;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter (WIDTH=8, SYNC_STAGES=2): vector table plus hand sequences.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: none; all waits are fixed cycle counts.
module tb_prog_counter;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   tc_seen;
    int   tc0;

    prog_counter_if #(.WIDTH(8)) bus_if ();

    prog_counter #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Running count of tc pulses, one per cycle tc is high.
    always @(negedge clk) begin
        if (rst) tc_seen <= 0;
        else if (bus_if.tc) tc_seen <= tc_seen + 1;
    end

    typedef enum logic [1:0] {OP_CFG, OP_LOAD, OP_UP, OP_DOWN} op_e;

    typedef struct {
        op_e        op;
        logic [7:0] val;        // limit for OP_CFG, data for OP_LOAD
        logic       sat;        // sat_mode for OP_CFG
        logic [7:0] exp_count;
        int         exp_tc;     // tc pulses expected during this row
    } vec_t;

    vec_t vecs[$];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pulse_cnt(input logic up);
        bus_if.up_down = up;
        cyc(3);
        bus_if.count_in = 1'b1;
        cyc(2);
        bus_if.count_in = 1'b0;
        cyc(3);
    endtask

    task automatic do_load(input logic [7:0] d);
        bus_if.data_in = d;
        cyc(4);
        bus_if.load = 1'b1;
        cyc(2);
        bus_if.load = 1'b0;
        cyc(4);
    endtask

    task automatic do_cfg(input logic [7:0] lim, input logic sat);
        bus_if.enable = 1'b0;
        cyc(4);
        bus_if.limit    = lim;
        bus_if.sat_mode = sat;
        cyc(1);
        bus_if.enable = 1'b1;
        cyc(5);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus_if.enable   = 1'b0;
        bus_if.count_in = 1'b0;
        bus_if.load     = 1'b0;
        bus_if.up_down  = 1'b1;
        bus_if.data_in  = 8'h00;
        bus_if.limit    = 8'hFF;
        bus_if.sat_mode = 1'b0;

        // Vector table: wrap up, saturate both ways, wrap down, limit=0, full range.
        vecs.push_back('{OP_CFG,  8'd9,   1'b0, 8'd0,   0});
        vecs.push_back('{OP_LOAD, 8'd8,   1'b0, 8'd8,   0});
        vecs.push_back('{OP_UP,   8'd0,   1'b0, 8'd9,   0});
        vecs.push_back('{OP_UP,   8'd0,   1'b0, 8'd0,   1});
        vecs.push_back('{OP_UP,   8'd0,   1'b0, 8'd1,   0});
        vecs.push_back('{OP_CFG,  8'd9,   1'b1, 8'd0,   0});
        vecs.push_back('{OP_LOAD, 8'd200, 1'b0, 8'd200, 0});
        vecs.push_back('{OP_UP,   8'd0,   1'b0, 8'd9,   1});
        vecs.push_back('{OP_LOAD, 8'd0,   1'b0, 8'd0,   0});
        vecs.push_back('{OP_DOWN, 8'd0,   1'b0, 8'd0,   1});
        vecs.push_back('{OP_DOWN, 8'd0,   1'b0, 8'd0,   1});
        vecs.push_back('{OP_CFG,  8'h3C,  1'b0, 8'd0,   0});
        vecs.push_back('{OP_DOWN, 8'd0,   1'b0, 8'h3C,  1});
        vecs.push_back('{OP_DOWN, 8'd0,   1'b0, 8'h3B,  0});
        vecs.push_back('{OP_CFG,  8'd0,   1'b0, 8'd0,   0});
        vecs.push_back('{OP_UP,   8'd0,   1'b0, 8'd0,   1});
        vecs.push_back('{OP_CFG,  8'd0,   1'b1, 8'd0,   0});
        vecs.push_back('{OP_LOAD, 8'd5,   1'b0, 8'd5,   0});
        vecs.push_back('{OP_UP,   8'd0,   1'b0, 8'd0,   1});
        vecs.push_back('{OP_CFG,  8'hFF,  1'b0, 8'd0,   0});
        vecs.push_back('{OP_LOAD, 8'hFE,  1'b0, 8'hFE,  0});
        vecs.push_back('{OP_UP,   8'd0,   1'b0, 8'hFF,  0});
        vecs.push_back('{OP_UP,   8'd0,   1'b0, 8'h00,  1});

        // Reset state
        cyc(3);
        chk("reset count", 32'(bus_if.count), 32'h0);
        chk("reset tc", 32'(bus_if.tc), 32'h0);
        chk("reset enabled", 32'(bus_if.enabled), 32'h0);
        rst = 1'b0;
        cyc(2);

        // enabled follows the pin at edge 2
        bus_if.enable = 1'b1;
        cyc(1);
        chk("enabled after edge1", 32'(bus_if.enabled), 32'h0);
        cyc(1);
        chk("enabled after edge2", 32'(bus_if.enabled), 32'h1);
        cyc(4);

        // First count lands at edge 3 after the capturing edge
        bus_if.up_down = 1'b1;
        cyc(3);
        bus_if.count_in = 1'b1;
        cyc(1);
        chk("latency edge1", 32'(bus_if.count), 32'h0);
        cyc(1);
        chk("latency edge2", 32'(bus_if.count), 32'h0);
        bus_if.count_in = 1'b0;
        cyc(1);
        chk("latency edge3", 32'(bus_if.count), 32'h1);
        cyc(2);
        for (int k = 0; k < 4; k++) pulse_cnt(1'b1);
        chk("five counts", 32'(bus_if.count), 32'h5);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            tc0 = tc_seen;
            case (vecs[i].op)
                OP_CFG:  do_cfg(vecs[i].val, vecs[i].sat);
                OP_LOAD: do_load(vecs[i].val);
                OP_UP:   pulse_cnt(1'b1);
                default: pulse_cnt(1'b0);
            endcase
            chk($sformatf("vec%0d count", i), 32'(bus_if.count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d tc pulses", i), 32'(tc_seen - tc0), 32'(vecs[i].exp_tc));
        end

        // Priority: coincident load and count strobe -> load only
        do_cfg(8'hFF, 1'b0);
        tc0 = tc_seen;
        bus_if.data_in = 8'h55;
        bus_if.up_down = 1'b1;
        cyc(4);
        bus_if.load = 1'b1;
        bus_if.count_in = 1'b1;
        cyc(2);
        bus_if.load = 1'b0;
        bus_if.count_in = 1'b0;
        cyc(4);
        chk("load beats count", 32'(bus_if.count), 32'h55);
        chk("load beats count tc", 32'(tc_seen - tc0), 32'h0);

        // Disabled: count and load ignored, value retained
        bus_if.enable = 1'b0;
        cyc(4);
        chk("disabled status", 32'(bus_if.enabled), 32'h0);
        pulse_cnt(1'b1);
        chk("disabled count held", 32'(bus_if.count), 32'h55);
        do_load(8'h11);
        chk("disabled load ignored", 32'(bus_if.count), 32'h55);

        // Re-enable with a coincident load edge -> clear wins
        bus_if.data_in = 8'h22;
        cyc(4);
        bus_if.enable = 1'b1;
        bus_if.load = 1'b1;
        cyc(2);
        bus_if.load = 1'b0;
        cyc(4);
        chk("enable beats load", 32'(bus_if.count), 32'h0);
        chk("re-enabled status", 32'(bus_if.enabled), 32'h1);

        // Async reset mid-count with a count strobe in flight
        do_load(8'h7F);
        chk("preload 0x7F", 32'(bus_if.count), 32'h7F);
        bus_if.up_down = 1'b1;
        cyc(3);
        bus_if.count_in = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst count", 32'(bus_if.count), 32'h0);
        chk("async rst tc", 32'(bus_if.tc), 32'h0);
        chk("async rst enabled", 32'(bus_if.enabled), 32'h0);
        @(negedge clk);
        bus_if.count_in = 1'b0;
        cyc(2);
        rst = 1'b0;
        tc0 = tc_seen;
        cyc(8);
        chk("post rst count", 32'(bus_if.count), 32'h0);
        chk("post rst tc", 32'(tc_seen - tc0), 32'h0);
        chk("post rst enabled", 32'(bus_if.enabled), 32'h1);
        pulse_cnt(1'b1);
        chk("post rst step", 32'(bus_if.count), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
